// File: rtl/pcap_pkg.sv
// ----------------------------------------------------------------------------
// pcap_pkg: shared types and defaults for the pcap replay datapath. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pcap_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   localparam int DEFAULT_TDATA_WIDTH = 512;
   localparam int PKT_MTU_BYTE        = 1518;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: combinational round-robin find-first, searching from last+1. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] last_i,
   output logic [$clog2(N)-1:0] gnt_idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   logic [IW:0] cand;

   // Walk from the farthest candidate to the nearest so the last hit wins.
   always_comb begin
      gnt_idx_o = '0;
      any_o     = |req_i;
      cand      = '0;
      for (int i = N; i >= 1; i--) begin
         cand = {1'b0, last_i} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (req_i[cand[IW-1:0]]) begin
            gnt_idx_o = cand[IW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// axis_pkt_arbiter: packet-atomic round-robin AXI-Stream arbiter with IPG. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_pkt_arbiter
   import pcap_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
   parameter int IPG_CYCLES  = 0,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      enable,
   input  logic [NUM_PORTS-1:0][TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [NUM_PORTS-1:0][TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
   input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
   output logic [NUM_PORTS-1:0]                      s_axis_tready,
   output logic [TDATA_WIDTH-1:0]                    m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]                  m_axis_tkeep,
   output logic                                      m_axis_tlast,
   output logic [$clog2(NUM_PORTS)-1:0]              m_axis_tid,
   output logic                                      m_axis_tvalid,
   input  logic                                      m_axis_tready,
   output logic [CNT_WIDTH-1:0]                      pkt_count,
   output logic                                      busy
);

   localparam int ID_W = $clog2(NUM_PORTS);

   arb_state_t           state_q;
   logic [ID_W-1:0]      grant_q;
   logic [ID_W-1:0]      last_grant_q;
   logic [7:0]           gap_cnt_q;
   logic [CNT_WIDTH-1:0] pkt_count_q;
   logic [CNT_WIDTH-1:0] pkt_count_d;
   logic [ID_W-1:0]      pick_idx;
   logic                 pick_any;
   logic                 tail_hs;

   rr_picker #(
      .N (NUM_PORTS)
   ) u_picker (
      .req_i     (s_axis_tvalid),
      .last_i    (last_grant_q),
      .gnt_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   assign tail_hs     = (state_q == BUSY) && s_axis_tvalid[grant_q]
                        && m_axis_tready && s_axis_tlast[grant_q];
   assign pkt_count_d = pkt_count_q + CNT_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_PORTS - 1);
         gap_cnt_q    <= '0;
         pkt_count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable && pick_any) begin
                  grant_q <= pick_idx;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (tail_hs) begin
                  last_grant_q <= grant_q;
                  pkt_count_q  <= pkt_count_d;
                  if (IPG_CYCLES > 0) begin
                     state_q   <= GAP;
                     gap_cnt_q <= 8'(IPG_CYCLES - 1);
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == 8'd0) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Pass-through mux; tready never depends on tvalid, keeping the path acyclic.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tid    = '0;
      s_axis_tready = '0;
      if (state_q == BUSY) begin
         m_axis_tdata           = s_axis_tdata[grant_q];
         m_axis_tkeep           = s_axis_tkeep[grant_q];
         m_axis_tlast           = s_axis_tlast[grant_q];
         m_axis_tvalid          = s_axis_tvalid[grant_q];
         m_axis_tid             = grant_q;
         s_axis_tready[grant_q] = m_axis_tready;
      end
   end

   assign pkt_count = pkt_count_q;
   assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axis_pkt_arbiter: scoreboard bench, IPG=0 and IPG=12 instances. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axis_pkt_arbiter;

   localparam int NP = 4;
   localparam int DW = 512;
   localparam int KW = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [1:0]    tid;
   } flit_t;

   logic clk = 1'b0;
   logic rst_n, en0, en1, sel, m_tready;
   logic [NP-1:0][DW-1:0] s_tdata;
   logic [NP-1:0][KW-1:0] s_tkeep;
   logic [NP-1:0]         s_tlast, s_tvalid;

   logic [NP-1:0] s_tready0, s_tready1;
   logic [DW-1:0] m_tdata0, m_tdata1;
   logic [KW-1:0] m_tkeep0, m_tkeep1;
   logic          m_tlast0, m_tlast1, m_tvalid0, m_tvalid1, busy0, busy1;
   logic [1:0]    m_tid0, m_tid1;
   logic [31:0]   pc0, pc1;

   logic [NP-1:0] src_rdy;
   logic [DW-1:0] md;
   logic [KW-1:0] mk;
   logic          ml, mv, busy_s;
   logic [1:0]    mt;

   assign src_rdy = sel ? s_tready1 : s_tready0;
   assign md      = sel ? m_tdata1  : m_tdata0;
   assign mk      = sel ? m_tkeep1  : m_tkeep0;
   assign ml      = sel ? m_tlast1  : m_tlast0;
   assign mv      = sel ? m_tvalid1 : m_tvalid0;
   assign mt      = sel ? m_tid1    : m_tid0;
   assign busy_s  = sel ? busy1     : busy0;

   axis_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .IPG_CYCLES(0), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .enable(en0),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
      .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tlast(m_tlast0),
      .m_axis_tid(m_tid0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
      .pkt_count(pc0), .busy(busy0)
   );

   axis_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .IPG_CYCLES(12), .CNT_WIDTH(32)) dut_ipg (
      .clk(clk), .rst_n(rst_n), .enable(en1),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
      .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tlast(m_tlast1),
      .m_axis_tid(m_tid1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
      .pkt_count(pc1), .busy(busy1)
   );

   always #5 clk = ~clk;

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    hs_n = 0;
   int    idle_n = 0;
   bit    rnd = 1'b0;
   bit    rdy_chk = 1'b0;
   flit_t srcq [NP][$];
   flit_t expq [$];
   int    hs_t [$];
   int    idle_snap [$];
   logic [NP-1:0] src_hs;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pkt(input int p, input int nbytes);
      int    rem;
      int    k;
      flit_t f;
      rem = nbytes;
      while (rem > 0) begin
         k = (rem > KW) ? KW : rem;
         for (int w = 0; w < DW / 32; w++) f.data[w*32 +: 32] = $urandom;
         f.keep = '0;
         for (int b = 0; b < k; b++) f.keep[b] = 1'b1;
         rem   -= k;
         f.last = (rem == 0);
         f.tid  = 2'(p);
         srcq[p].push_back(f);
         expq.push_back(f);
      end
   endtask

   task automatic clear_all();
      for (int p = 0; p < NP; p++) srcq[p].delete();
      expq.delete();
      hs_t.delete();
      idle_snap.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      clear_all();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_hs(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (hs_n < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      chk({tag, "_hs_reached"}, 512'(hs_n >= n), 512'(1));
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int i;
      i = 0;
      while (expq.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      chk({tag, "_drained"}, 512'(expq.size()), 512'(0));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Source model: one process drives every port from its flit queue.
   initial begin
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tvalid = '0;
      m_tready = 1'b1;
      forever begin
         @(negedge clk);
         src_hs = s_tvalid & src_rdy;
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (src_hs[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            if (srcq[p].size() > 0) begin
               s_tdata[p]  = srcq[p][0].data;
               s_tkeep[p]  = srcq[p][0].keep;
               s_tlast[p]  = srcq[p][0].last;
               s_tvalid[p] = 1'b1;
            end else begin
               s_tdata[p]  = '0;
               s_tkeep[p]  = '0;
               s_tlast[p]  = 1'b0;
               s_tvalid[p] = 1'b0;
            end
         end
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Egress monitor: pops the scoreboard on every handshake of the selected DUT.
   initial begin
      flit_t         e;
      logic [NP-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         if (rst_n && mv && m_tready) begin
            hs_n++;
            hs_t.push_back(cyc);
            idle_snap.push_back(idle_n);
            tests++;
            assert (expq.size() != 0) else begin
               fails++;
               $error("FAIL extra_flit: observed tid %0d expected no flit", mt);
            end
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("tdata", 512'(md), 512'(e.data));
               chk("tkeep", 512'(mk), 512'(e.keep));
               chk("tlast", 512'(ml), 512'(e.last));
               chk("tid",   512'(mt), 512'(e.tid));
            end
         end
         if (rdy_chk && mv) begin
            exp_rdy    = '0;
            exp_rdy[1] = m_tready;
            chk("s_tready_mirror", 512'(src_rdy), 512'(exp_rdy));
         end
         if (!busy_s) idle_n++;
      end
   end

   initial begin
      int t1_exp [4];
      int base;
      int i;
      t1_exp = '{2, 1, 2, 1};
      rst_n = 1'b0;
      en0   = 1'b1;
      en1   = 1'b0;
      sel   = 1'b0;

      #3;
      chk("rst_m_tvalid", 512'(m_tvalid0), 512'(0));
      chk("rst_pkt_count", 512'(pc0), 512'(0));
      chk("rst_busy", 512'({busy0, busy1}), 512'(0));
      chk("rst_s_tready", 512'({s_tready0, s_tready1}), 512'(0));
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: sole requester, 64/65/128 bytes
      hs_t.delete();
      load_pkt(0, 64);
      load_pkt(0, 65);
      load_pkt(0, 128);
      wait_drain(200, "t1");
      @(negedge clk);
      chk("t1_flits", 512'(hs_t.size()), 512'(5));
      for (int k = 1; k < 5 && k < hs_t.size(); k++)
         chk("t1_spacing", 512'(hs_t[k] - hs_t[k-1]), 512'(t1_exp[k-1]));
      chk("t1_pkt_count", 512'(pc0), 512'(3));

      // 2: all ports, order 0,1,2,3,0
      do_reset();
      load_pkt(0, 128);
      load_pkt(1, 128);
      load_pkt(2, 128);
      load_pkt(3, 128);
      load_pkt(0, 128);
      wait_drain(300, "t2");
      @(negedge clk);
      chk("t2_pkt_count", 512'(pc0), 512'(5));

      // 3: IPG=12 instance, back-to-back single flits on port 2
      sel = 1'b1;
      en0 = 1'b0;
      en1 = 1'b1;
      do_reset();
      load_pkt(2, 64);
      load_pkt(2, 64);
      load_pkt(2, 64);
      wait_drain(300, "t3");
      @(negedge clk);
      chk("t3_flits", 512'(hs_t.size()), 512'(3));
      for (int k = 1; k < 3 && k < hs_t.size(); k++) begin
         chk("t3_spacing", 512'(hs_t[k] - hs_t[k-1]), 512'(14));
         chk("t3_idle_cycles", 512'(idle_snap[k] - idle_snap[k-1]), 512'(1));
      end
      chk("t3_pkt_count", 512'(pc1), 512'(3));

      // 4: random backpressure on a 5-flit packet from port 1
      @(posedge clk);
      #2;
      en1 = 1'b0;
      sel = 1'b0;
      en0 = 1'b1;
      rnd = 1'b1;
      rdy_chk = 1'b1;
      load_pkt(1, 320);
      wait_drain(400, "t4");
      rnd = 1'b0;
      rdy_chk = 1'b0;

      // 5: enable dropped mid-packet on port 3
      do_reset();
      base = hs_n;
      load_pkt(3, 256);
      wait_hs(base + 1, 100, "t5");
      #2 en0 = 1'b0;
      load_pkt(0, 64);
      load_pkt(2, 64);
      i = 0;
      while (expq.size() > 2 && i < 100) begin
         @(posedge clk);
         i++;
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t5_no_grant_disabled", 512'(expq.size()), 512'(2));
      chk("t5_idle_disabled", 512'(busy0), 512'(0));
      chk("t5_pkt_count", 512'(pc0), 512'(1));
      #2 en0 = 1'b1;
      wait_drain(200, "t5");

      // 6: reset on flit 3 of 8
      base = hs_n;
      load_pkt(0, 512);
      wait_hs(base + 2, 100, "t6");
      #2;
      chk("t6_pre_reset_valid", 512'(m_tvalid0), 512'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tvalid", 512'(m_tvalid0), 512'(0));
      chk("t6_rst_tdata", 512'(m_tdata0), 512'(0));
      chk("t6_rst_tkeep_tlast_tid", 512'({m_tkeep0, m_tlast0, m_tid0}), 512'(0));
      chk("t6_rst_s_tready", 512'(s_tready0), 512'(0));
      chk("t6_rst_busy", 512'(busy0), 512'(0));
      chk("t6_rst_pkt_count", 512'(pc0), 512'(0));
      clear_all();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      load_pkt(1, 64);
      load_pkt(2, 64);
      @(negedge clk);
      chk("t6_pkt_count_restart", 512'(pc0), 512'(0));
      wait_drain(200, "t6");
      @(negedge clk);
      chk("t6_pkt_count_after", 512'(pc0), 512'(2));

      chk("scoreboard_empty", 512'(expq.size()), 512'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
